ysyx_201979054_axi_req_arbiter: RTL and testbench

//   Shares the single AXI4 master between two cache-side requesters: port 0 (I-cache refill) and port 1 (D-cache refill/writeback/non-cacheable).

---
 rtl/ysyx_201979054_axi_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_ysyx_201979054_axi_req_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_201979054_axi_req_arbiter.sv
// Purpose: shares one AXI4 master between I-cache (port 0) and D-cache (port 1); optional ARB_ROUND_ROBIN_EN.
// Latency: request sampled in IDLE drives o_read_req/o_write_req on the next cycle; beat/done paths are combinational.
// Backpressure: requests are level-held until o_pN_done; the losing port simply waits, no credits involved.
module ysyx_201979054_axi_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_p0_read_req,
  input  logic                  i_p0_write_req,
  input  logic [ADDR_WIDTH-1:0] i_p0_addr,
  input  logic [7:0]            i_p0_len,
  input  logic [2:0]            i_p0_size,
  input  logic [7:0]            i_p0_strb,
  input  logic [DATA_WIDTH-1:0] i_p0_wdata,
  output logic [DATA_WIDTH-1:0] o_p0_rdata,
  output logic                  o_p0_handshake,
  output logic                  o_p0_done,
  input  logic                  i_p1_read_req,
  input  logic                  i_p1_write_req,
  input  logic [ADDR_WIDTH-1:0] i_p1_addr,
  input  logic [7:0]            i_p1_len,
  input  logic [2:0]            i_p1_size,
  input  logic [7:0]            i_p1_strb,
  input  logic [DATA_WIDTH-1:0] i_p1_wdata,
  output logic [DATA_WIDTH-1:0] o_p1_rdata,
  output logic                  o_p1_handshake,
  output logic                  o_p1_done,
  output logic                  o_read_req,
  output logic                  o_write_req,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [7:0]            o_len,
  output logic [2:0]            o_size,
  output logic [7:0]            o_strb,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_handshake,
  input  logic                  i_done,
  output logic [1:0]            o_grant
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t state;
  logic   req0;
  logic   req1;
  logic   pick1;
  logic   fwd0;
  logic   fwd1;

`ifdef ARB_ROUND_ROBIN_EN
  // Index of the most recent winner; reset to 1 so the first tie favours port 0.
  logic   last_grant;
`endif

  // Winner selection: a lone requester always wins; ties resolved by the build-time policy.
  always_comb begin
    req0 = i_p0_read_req | i_p0_write_req;
    req1 = i_p1_read_req | i_p1_write_req;
`ifdef ARB_ROUND_ROBIN_EN
    pick1 = req1 & (~req0 | ~last_grant);
`else
    pick1 = req1;
`endif
  end

  // Return path: only the owner of an active burst sees beats, handshakes and done.
  always_comb begin
    fwd0           = (state == S_BUSY) & o_grant[0];
    fwd1           = (state == S_BUSY) & o_grant[1];
    o_p0_rdata     = fwd0 ? i_rdata : '0;
    o_p1_rdata     = fwd1 ? i_rdata : '0;
    o_p0_handshake = fwd0 & i_handshake;
    o_p1_handshake = fwd1 & i_handshake;
    o_p0_done      = fwd0 & i_done;
    o_p1_done      = fwd1 & i_done;
    o_wdata        = fwd1 ? i_p1_wdata : (fwd0 ? i_p0_wdata : '0);
  end

  // Grant FSM: latch the winner's command in IDLE, hold it through BUSY, spend one RELEASE cycle
  // so the finished requester can drop its level request before the next arbitration.
  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= S_IDLE;
      o_read_req  <= 1'b0;
      o_write_req <= 1'b0;
      o_addr      <= '0;
      o_len       <= '0;
      o_size      <= '0;
      o_strb      <= '0;
      o_grant     <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            state <= S_BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= pick1;
`endif
            if (pick1) begin
              o_grant     <= 2'b10;
              o_write_req <= i_p1_write_req;
              o_read_req  <= ~i_p1_write_req;
              o_addr      <= i_p1_addr;
              o_len       <= i_p1_len;
              o_size      <= i_p1_size;
              o_strb      <= i_p1_strb;
            end else begin
              o_grant     <= 2'b01;
              o_write_req <= i_p0_write_req;
              o_read_req  <= ~i_p0_write_req;
              o_addr      <= i_p0_addr;
              o_len       <= i_p0_len;
              o_size      <= i_p0_size;
              o_strb      <= i_p0_strb;
            end
          end
        end
        S_BUSY: begin
          if (i_done) begin
            state       <= S_RELEASE;
            o_read_req  <= 1'b0;
            o_write_req <= 1'b0;
            o_grant     <= 2'b00;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_201979054_axi_req_arbiter.sv
// Purpose: directed self-checking bench for the two-port AXI request arbiter.
// Latency: inputs change 1ns after a rising edge; outputs are checked 1ns after that.
// Backpressure: AXI master side is emulated directly by driving i_handshake/i_done.
module tb_ysyx_201979054_axi_req_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic        i_p0_read_req, i_p0_write_req;
  logic [31:0] i_p0_addr;
  logic [7:0]  i_p0_len;
  logic [2:0]  i_p0_size;
  logic [7:0]  i_p0_strb;
  logic [63:0] i_p0_wdata;
  logic [63:0] o_p0_rdata;
  logic        o_p0_handshake, o_p0_done;
  logic        i_p1_read_req, i_p1_write_req;
  logic [31:0] i_p1_addr;
  logic [7:0]  i_p1_len;
  logic [2:0]  i_p1_size;
  logic [7:0]  i_p1_strb;
  logic [63:0] i_p1_wdata;
  logic [63:0] o_p1_rdata;
  logic        o_p1_handshake, o_p1_done;
  logic        o_read_req, o_write_req;
  logic [31:0] o_addr;
  logic [7:0]  o_len;
  logic [2:0]  o_size;
  logic [7:0]  o_strb;
  logic [63:0] o_wdata;
  logic [63:0] i_rdata;
  logic        i_handshake, i_done;
  logic [1:0]  o_grant;

  int tests = 0;
  int fails = 0;
  int hs_count;
  logic       first_is_p1;
  logic [1:0] first_grant;
  logic [1:0] second_grant;

  ysyx_201979054_axi_req_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clk(clk), .arst(arst),
    .i_p0_read_req(i_p0_read_req), .i_p0_write_req(i_p0_write_req),
    .i_p0_addr(i_p0_addr), .i_p0_len(i_p0_len), .i_p0_size(i_p0_size),
    .i_p0_strb(i_p0_strb), .i_p0_wdata(i_p0_wdata),
    .o_p0_rdata(o_p0_rdata), .o_p0_handshake(o_p0_handshake), .o_p0_done(o_p0_done),
    .i_p1_read_req(i_p1_read_req), .i_p1_write_req(i_p1_write_req),
    .i_p1_addr(i_p1_addr), .i_p1_len(i_p1_len), .i_p1_size(i_p1_size),
    .i_p1_strb(i_p1_strb), .i_p1_wdata(i_p1_wdata),
    .o_p1_rdata(o_p1_rdata), .o_p1_handshake(o_p1_handshake), .o_p1_done(o_p1_done),
    .o_read_req(o_read_req), .o_write_req(o_write_req),
    .o_addr(o_addr), .o_len(o_len), .o_size(o_size), .o_strb(o_strb),
    .o_wdata(o_wdata), .i_rdata(i_rdata), .i_handshake(i_handshake),
    .i_done(i_done), .o_grant(o_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    first_is_p1 = 1'b0;
`else
    first_is_p1 = 1'b1;
`endif
    first_grant  = first_is_p1 ? 2'b10 : 2'b01;
    second_grant = first_is_p1 ? 2'b01 : 2'b10;

    arst = 1'b1;
    i_p0_read_req = 0; i_p0_write_req = 0; i_p0_addr = '0; i_p0_len = '0;
    i_p0_size = '0; i_p0_strb = '0; i_p0_wdata = '0;
    i_p1_read_req = 0; i_p1_write_req = 0; i_p1_addr = '0; i_p1_len = '0;
    i_p1_size = '0; i_p1_strb = '0; i_p1_wdata = '0;
    i_rdata = '0; i_handshake = 0; i_done = 0;
    step(); step();

    // Reset state
    check("rst_grant", 64'(o_grant), 64'h0);
    check("rst_rreq", 64'(o_read_req), 64'h0);
    check("rst_wreq", 64'(o_write_req), 64'h0);
    check("rst_addr", 64'(o_addr), 64'h0);
    check("rst_wdata", o_wdata, 64'h0);

    // Tie on the first arbitration after reset
    arst = 1'b0;
    i_p0_read_req = 1; i_p0_addr = 32'h3000_0000; i_p0_len = 8'd0; i_p0_size = 3'd3;
    i_p1_read_req = 1; i_p1_addr = 32'h8000_0000; i_p1_len = 8'd3; i_p1_size = 3'd2;
    #1;
    check("tie_pre_grant", 64'(o_grant), 64'h0);
    step();
    check("tie_grant1", 64'(o_grant), 64'(first_grant));
    check("tie_rreq1", 64'(o_read_req), 64'h1);
    check("tie_addr1", 64'(o_addr), first_is_p1 ? 64'h8000_0000 : 64'h3000_0000);
    check("tie_len1", 64'(o_len), first_is_p1 ? 64'h3 : 64'h0);
    i_done = 1; #1;
    check("tie_done0_1", 64'(o_p0_done), first_is_p1 ? 64'h0 : 64'h1);
    check("tie_done1_1", 64'(o_p1_done), first_is_p1 ? 64'h1 : 64'h0);
    step();
    i_done = 0;
    if (first_is_p1) i_p1_read_req = 0; else i_p0_read_req = 0;
    #1;
    check("tie_rel_grant", 64'(o_grant), 64'h0);
    check("tie_rel_rreq", 64'(o_read_req), 64'h0);
    step();
    check("tie_idle_grant", 64'(o_grant), 64'h0);
    step();
    check("tie_grant2", 64'(o_grant), 64'(second_grant));
    check("tie_addr2", 64'(o_addr), first_is_p1 ? 64'h3000_0000 : 64'h8000_0000);
    i_done = 1; step(); i_done = 0;
    i_p0_read_req = 0; i_p1_read_req = 0;
    step(); step();

    // Port 0 alone; command must stay frozen while the requester misbehaves
    i_p0_read_req = 1; i_p0_addr = 32'h3000_0000; i_p0_len = 8'd0;
    step();
    check("p0_grant", 64'(o_grant), 64'h1);
    check("p0_rreq", 64'(o_read_req), 64'h1);
    check("p0_wreq", 64'(o_write_req), 64'h0);
    check("p0_addr", 64'(o_addr), 64'h3000_0000);
    i_p0_addr = 32'h1234_5678; i_p0_read_req = 0;
    step();
    check("p0_hold_addr", 64'(o_addr), 64'h3000_0000);
    check("p0_hold_rreq", 64'(o_read_req), 64'h1);
    i_handshake = 1; i_rdata = 64'hDEAD_BEEF_0000_AA55; #1;
    check("p0_rdata", o_p0_rdata, 64'hDEAD_BEEF_0000_AA55);
    check("p0_hs", 64'(o_p0_handshake), 64'h1);
    check("p1_rdata_zero", o_p1_rdata, 64'h0);
    check("p1_hs_zero", 64'(o_p1_handshake), 64'h0);
    i_handshake = 0; i_done = 1; #1;
    check("p0_done", 64'(o_p0_done), 64'h1);
    check("p1_done_zero", 64'(o_p1_done), 64'h0);
    step();
    i_done = 1; i_handshake = 1; #1;
    check("rel_done_ignored", 64'(o_p0_done), 64'h0);
    check("rel_hs_ignored", 64'(o_p0_handshake), 64'h0);
    check("rel_rdata_ignored", o_p0_rdata, 64'h0);
    i_done = 0; i_handshake = 0;
    step();
    check("p0_idle_grant", 64'(o_grant), 64'h0);

    // Port 1 read+write together: write first, then the read
    i_p1_read_req = 1; i_p1_write_req = 1; i_p1_addr = 32'h8000_0040;
    i_p1_len = 8'd7; i_p1_size = 3'd3; i_p1_strb = 8'hF0;
    step();
    check("p1_w_grant", 64'(o_grant), 64'h2);
    check("p1_w_wreq", 64'(o_write_req), 64'h1);
    check("p1_w_rreq", 64'(o_read_req), 64'h0);
    check("p1_w_strb", 64'(o_strb), 64'hF0);
    check("p1_w_len", 64'(o_len), 64'h7);
    check("p1_w_addr", 64'(o_addr), 64'h8000_0040);
    hs_count = 0;
    for (int i = 0; i < 8; i++) begin
      i_p1_wdata = 64'hCAFE_0000_0000_1000 + 64'(i);
      i_p0_wdata = 64'h5555_5555_5555_5555;
      i_handshake = 1;
      i_done = (i == 7);
      #1;
      check("p1_wdata_beat", o_wdata, 64'hCAFE_0000_0000_1000 + 64'(i));
      check("p0_hs_quiet", 64'(o_p0_handshake), 64'h0);
      check("p0_done_quiet", 64'(o_p0_done), 64'h0);
      if (o_p1_handshake) hs_count++;
      step();
    end
    i_handshake = 0; i_done = 0; i_p1_write_req = 0;
    check("p1_hs_count", 64'(hs_count), 64'h8);
    check("p1_rel_wreq", 64'(o_write_req), 64'h0);
    step();
    step();
    check("p1_r_grant", 64'(o_grant), 64'h2);
    check("p1_r_rreq", 64'(o_read_req), 64'h1);
    check("p1_r_wreq", 64'(o_write_req), 64'h0);
    i_done = 1; #1;
    check("p1_r_done", 64'(o_p1_done), 64'h1);
    step();
    i_done = 0; i_p1_read_req = 0;
    step();

    // Reset in the middle of a burst, then a fresh grant
    i_p0_write_req = 1; i_p0_addr = 32'h0000_2000; i_p0_len = 8'd7; i_p0_strb = 8'hFF;
    step();
    check("p0_w_wreq", 64'(o_write_req), 64'h1);
    for (int i = 0; i < 3; i++) begin
      i_handshake = 1;
      step();
    end
    i_handshake = 0;
    arst = 1;
    step();
    check("mid_rst_grant", 64'(o_grant), 64'h0);
    check("mid_rst_wreq", 64'(o_write_req), 64'h0);
    check("mid_rst_rreq", 64'(o_read_req), 64'h0);
    arst = 0;
    step();
    check("post_rst_grant", 64'(o_grant), 64'h1);
    check("post_rst_wreq", 64'(o_write_req), 64'h1);
    check("post_rst_addr", 64'(o_addr), 64'h0000_2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
